// File: rtl/dt_pkg.sv
// Shared constants, state encoding and neighbour offsets for the two-pass
// chamfer distance transform (forward and backward passes).
package dt_pkg;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int STI_W  = 16;

    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int PIX_W  = $clog2(STI_W);
    localparam int STI_AW = ADDR_W - PIX_W;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

    localparam logic [ADDR_W-1:0] OFF_NW = ADDR_W'(129);
    localparam logic [ADDR_W-1:0] OFF_N  = ADDR_W'(128);
    localparam logic [ADDR_W-1:0] OFF_NE = ADDR_W'(127);
    localparam logic [ADDR_W-1:0] OFF_W  = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        LOAD,
        WRITE,
        DONE
    } fwd_state_t;

    // Neighbour visiting order during LOAD: NW, N, NE, W.
    function automatic logic [ADDR_W-1:0] nb_offset(input logic [1:0] k);
        case (k)
            2'd0:    return OFF_NW;
            2'd1:    return OFF_N;
            2'd2:    return OFF_NE;
            default: return OFF_W;
        endcase
    endfunction

endpackage

// File: rtl/dt_min4_inc.sv
// Combinational minimum of four distances plus one, saturating at all-ones.
module dt_min4_inc
    import dt_pkg::*;
(
    input  logic [DATA_W-1:0] nb0,
    input  logic [DATA_W-1:0] nb1,
    input  logic [DATA_W-1:0] nb2,
    input  logic [DATA_W-1:0] nb3,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W:0] min01;
    logic [DATA_W:0] min23;
    logic [DATA_W:0] min_all;
    logic [DATA_W:0] sum;

    assign min01   = (nb0 < nb1) ? {1'b0, nb0} : {1'b0, nb1};
    assign min23   = (nb2 < nb3) ? {1'b0, nb2} : {1'b0, nb3};
    assign min_all = (min01 < min23) ? min01 : min23;
    assign sum     = min_all + (DATA_W + 1)'(1);
    assign result  = sum[DATA_W] ? '1 : sum[DATA_W-1:0];

endmodule

// File: rtl/forward_pass.sv
// Forward chamfer pass: raster-scans sti_ROM and writes forward distances to res_RAM.
// Optional object-pixel counter output enabled by defining FWD_OBJ_CNT_EN.
module forward_pass
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              fwd_en,
    output logic [STI_AW-1:0] sti_addr,
    input  logic [STI_W-1:0]  sti_di,
    output logic [ADDR_W-1:0] res_addr_fwd,
    output logic              res_rd_fwd,
    output logic              res_wr_fwd,
    output logic [DATA_W-1:0] res_do_fwd,
    input  logic [DATA_W-1:0] res_di,
    output logic              fwd_done
`ifdef FWD_OBJ_CNT_EN
    ,
    output logic [ADDR_W-1:0] obj_count
`endif
);

    fwd_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] cur_reg;
    logic [1:0]        cnt_reg;
    logic [STI_W-1:0]  word_reg;
    logic [DATA_W-1:0] nb_reg [0:3];

    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [PIX_W-1:0]  bit_sel;
    logic              border;
    logic              obj_pix;
    logic [DATA_W-1:0] min_inc;

    assign row     = cur_reg[ADDR_W-1 -: ROW_W];
    assign col     = cur_reg[COL_W-1:0];
    assign bit_sel = PIX_W'(STI_W - 1) - cur_reg[PIX_W-1:0];
    assign border  = (row == '0) || (row == ROW_W'(IMG_H - 1)) ||
                     (col == '0) || (col == COL_W'(IMG_W - 1));
    assign obj_pix = word_reg[bit_sel] && !border;

    dt_min4_inc u_min4_inc (
        .nb0    (nb_reg[0]),
        .nb1    (nb_reg[1]),
        .nb2    (nb_reg[2]),
        .nb3    (nb_reg[3]),
        .result (min_inc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            cur_reg   <= '0;
            cnt_reg   <= '0;
            word_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                FETCH: word_reg <= sti_di;
                CHECK: cnt_reg  <= '0;
                LOAD:  cnt_reg  <= cnt_reg + 2'd1;
                WRITE: if (cur_reg != LAST_PIX) cur_reg <= cur_reg + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    // Each neighbour slot captures the RAM read issued in its own LOAD cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nb
            always_ff @(posedge clk) begin
                if (!reset)
                    nb_reg[gi] <= '1;
                else if (state_reg == LOAD && cnt_reg == 2'(gi))
                    nb_reg[gi] <= res_di;
            end
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        sti_addr     = '0;
        res_addr_fwd = '0;
        res_rd_fwd   = 1'b0;
        res_wr_fwd   = 1'b0;
        res_do_fwd   = '0;
        fwd_done     = 1'b0;
        case (state_reg)
            IDLE: if (fwd_en) state_next = FETCH;
            FETCH: begin
                sti_addr   = cur_reg[ADDR_W-1:PIX_W];
                state_next = CHECK;
            end
            CHECK: state_next = obj_pix ? LOAD : WRITE;
            LOAD: begin
                res_rd_fwd   = 1'b1;
                res_addr_fwd = cur_reg - nb_offset(cnt_reg);
                if (cnt_reg == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                res_wr_fwd   = 1'b1;
                res_addr_fwd = cur_reg;
                res_do_fwd   = obj_pix ? min_inc : '0;
                if (cur_reg == LAST_PIX)
                    state_next = DONE;
                else if (cur_reg[PIX_W-1:0] == '1)
                    state_next = FETCH;
                else
                    state_next = CHECK;
            end
            DONE: fwd_done = 1'b1;
            default: state_next = IDLE;
        endcase
    end

`ifdef FWD_OBJ_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset)
            obj_count <= '0;
        else if (state_reg == IDLE && fwd_en)
            obj_count <= '0;
        else if (state_reg == WRITE && obj_pix)
            obj_count <= obj_count + ADDR_W'(1);
    end
`endif

endmodule

// File: tb/tb_forward_pass.sv
// Scoreboard bench for forward_pass: a geometric reference model fills expected
// read/write queues, a negedge monitor checks every RAM access against them.
module tb_forward_pass;

    localparam int W = 128;
    localparam int H = 128;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fwd_en = 1'b0;
    logic [9:0]  sti_addr;
    logic [15:0] sti_di;
    logic [13:0] res_addr_fwd;
    logic        res_rd_fwd;
    logic        res_wr_fwd;
    logic [7:0]  res_do_fwd;
    logic [7:0]  res_di;
    logic        fwd_done;
`ifdef FWD_OBJ_CNT_EN
    logic [13:0] obj_count;
`endif

    forward_pass dut (
        .clk          (clk),
        .reset        (reset),
        .fwd_en       (fwd_en),
        .sti_addr     (sti_addr),
        .sti_di       (sti_di),
        .res_addr_fwd (res_addr_fwd),
        .res_rd_fwd   (res_rd_fwd),
        .res_wr_fwd   (res_wr_fwd),
        .res_do_fwd   (res_do_fwd),
        .res_di       (res_di),
        .fwd_done     (fwd_done)
`ifdef FWD_OBJ_CNT_EN
        ,
        .obj_count    (obj_count)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] rom [0:1023];
    logic [7:0]  ram [0:NPIX-1];

    assign sti_di = rom[sti_addr];
    assign res_di = ram[res_addr_fwd];
    always @(posedge clk) if (res_wr_fwd) ram[res_addr_fwd] <= res_do_fwd;

    int checks = 0;
    int errors = 0;
    int exp_map [0:H-1][0:W-1];
    int wq_a[$];
    int wq_d[$];
    int rq_a[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("check %s = %0d", name, act);
        end
    endtask

    // Reference: distances from neighbour geometry; cycles from per-pixel cost rules.
    task automatic build_model(input int npix, output int cyc);
        int idx, m, v;
        logic [15:0] w;
        bit obj;
        cyc = 1 + NPIX / 16;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                idx = r * W + c;
                w = rom[idx / 16];
                obj = w[15 - (idx % 16)] && r != 0 && r != H - 1 && c != 0 && c != W - 1;
                if (obj) begin
                    m = exp_map[r-1][c-1];
                    if (exp_map[r-1][c] < m)   m = exp_map[r-1][c];
                    if (exp_map[r-1][c+1] < m) m = exp_map[r-1][c+1];
                    if (exp_map[r][c-1] < m)   m = exp_map[r][c-1];
                    v = (m + 1 > 255) ? 255 : m + 1;
                    cyc += 6;
                end else begin
                    v = 0;
                    cyc += 2;
                end
                exp_map[r][c] = v;
                if (idx < npix) begin
                    if (obj) begin
                        rq_a.push_back((r - 1) * W + (c - 1));
                        rq_a.push_back((r - 1) * W + c);
                        rq_a.push_back((r - 1) * W + (c + 1));
                        rq_a.push_back(r * W + (c - 1));
                    end
                    wq_a.push_back(idx);
                    wq_d.push_back(v);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (res_wr_fwd && res_rd_fwd) begin
                checks++; errors++;
                $display("FAIL strobes both high at addr=%0d", res_addr_fwd);
            end else if (res_wr_fwd) begin
                checks++;
                if (wq_a.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%0d", res_addr_fwd, res_do_fwd);
                end else begin
                    int a, d;
                    a = wq_a.pop_front();
                    d = wq_d.pop_front();
                    if (int'(res_addr_fwd) != a || int'(res_do_fwd) != d) begin
                        errors++;
                        $display("FAIL write actual=%0d:%0d required=%0d:%0d",
                                 res_addr_fwd, res_do_fwd, a, d);
                    end
                end
            end else if (res_rd_fwd) begin
                checks++;
                if (rq_a.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read addr=%0d", res_addr_fwd);
                end else begin
                    int a;
                    a = rq_a.pop_front();
                    if (int'(res_addr_fwd) != a) begin
                        errors++;
                        $display("FAIL read_addr actual=%0d required=%0d", res_addr_fwd, a);
                    end
                end
            end else if (res_addr_fwd != 0 || res_do_fwd != 0) begin
                checks++; errors++;
                $display("FAIL idle_bus actual=%0d:%0d required=0:0", res_addr_fwd, res_do_fwd);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sti_addr"}, int'(sti_addr), 0);
        chk({tag, "_res_addr"}, int'(res_addr_fwd), 0);
        chk({tag, "_rd"}, int'(res_rd_fwd), 0);
        chk({tag, "_wr"}, int'(res_wr_fwd), 0);
        chk({tag, "_do"}, int'(res_do_fwd), 0);
        chk({tag, "_done"}, int'(fwd_done), 0);
`ifdef FWD_OBJ_CNT_EN
        chk({tag, "_obj_count"}, int'(obj_count), 0);
`endif
    endtask

    task automatic start_clean();
        wq_a.delete(); wq_d.delete(); rq_a.delete();
        for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
        for (int i = 0; i < NPIX; i++) ram[i] = 8'hAA;
    endtask

    task automatic run_pass(input string tag, input int cyc);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        @(negedge clk);
        fwd_en = 1'b1;
        while (n < 40000 && !seen) begin
            @(posedge clk);
            n++;
            #1;
            fwd_en = 1'b0;
            if (fwd_done) seen = 1;
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_done_edges"}, n, cyc);
        repeat (2) @(negedge clk);
        chk({tag, "_writes_left"}, wq_a.size(), 0);
        chk({tag, "_reads_left"}, rq_a.size(), 0);
    endtask

    initial begin
        int cyc, nz;
        bit hit;

        start_clean();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Random image, aborted by reset during the first LOAD cycle of pixel 300.
        for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom & $urandom);
        rom[18] = rom[18] | 16'h0008;
        build_model(300, cyc);
        rq_a.push_back(300 - 129);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        fwd_en = 1'b1;
        @(negedge clk);
        fwd_en = 1'b0;
        hit = 0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            @(negedge clk);
            if (wq_a.size() == 0 && res_rd_fwd && res_addr_fwd == 14'd171) hit = 1;
        end
        chk("abort_reached_load_300", int'(hit), 1);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_ram300_untouched", int'(ram[300]), 32'hAA);
        chk("abort_ram299", int'(ram[299]), exp_map[2][43]);
        chk("abort_ram_1_1", int'(ram[W + 1]), exp_map[1][1]);
        chk("abort_reads_left", rq_a.size(), 0);
        check_reset_outputs("abort");

        // 3x3 object block at rows/cols 10..12, full pass after the abort.
        start_clean();
        for (int r = 10; r <= 12; r++) rom[r * 8] = 16'h0038;
        build_model(NPIX, cyc);
        @(negedge clk);
        reset = 1'b1;
        run_pass("block", cyc);
        for (int r = 10; r <= 12; r++) begin
            for (int c = 10; c <= 12; c++) begin
                int req;
                req = (r > 10 && c == 11) ? 2 : 1;
                chk($sformatf("block_px_%0d_%0d", r, c), int'(ram[r * W + c]), req);
            end
        end
        chk("block_px_9_11", int'(ram[9 * W + 11]), 0);
        chk("block_px_13_11", int'(ram[13 * W + 11]), 0);
`ifdef FWD_OBJ_CNT_EN
        chk("block_obj_count", int'(obj_count), 9);
`endif
        @(negedge clk);
        fwd_en = 1'b1;
        repeat (20) @(negedge clk);
        fwd_en = 1'b0;
        chk("block_done_held", int'(fwd_done), 1);
`ifdef FWD_OBJ_CNT_EN
        chk("block_obj_count_held", int'(obj_count), 9);
`endif

        // Single MSB-set word: exactly pixel (64,64) becomes 1.
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset2");
        start_clean();
        rom[516] = 16'h8000;
        build_model(NPIX, cyc);
        @(negedge clk);
        reset = 1'b1;
        run_pass("bitorder", 33797);
        chk("bitorder_px_8256", int'(ram[8256]), 1);
        nz = 0;
        for (int i = 0; i < NPIX; i++) if (ram[i] != 8'd0) nz++;
        chk("bitorder_nonzero", nz, 1);
`ifdef FWD_OBJ_CNT_EN
        chk("bitorder_obj_count", int'(obj_count), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
